pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Sequencer for the program-counter datapath. Each cycle it drives the PC block's select controls: pc_sel, reg_jmp, halt, siic.
- Arbitrates competing PC-update requests: decode redirects, exceptions, RTI, halt, memory/hazard stalls.
- Owns the EPC register, exception-nesting state and the fetch flush.
- Sits between decode/hazard logic and the PC block in the fetch stage.

Parameters:
- DATA_W, 16, PC/EPC width.
- EPC_RST, 16'h0000, EPC reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pc  in  DATA_W  current PC (PC block register output)
- imem_stall  in  1  instruction memory busy; fetch not complete
- imem_done  in  1  instruction memory returns fetch this cycle
- id_stall  in  1  decode hazard stall
- br_take  in  1  decoded J/JAL/taken branch
- jr_take  in  1  decoded JR/JALR
- halt_instr  in  1  decoded HALT
- siic_instr  in  1  decoded SIIC (software exception)
- rti_instr  in  1  decoded RTI
- pc_sel  out  1  PC block: PC+BrnchImm path
- reg_jmp  out  1  PC block: Rs+Imm path
- halt  out  1  PC block: hold PC
- siic  out  1  PC block: load exception vector (0x0002)
- epc_sel  out  1  steers EPC onto the PC block Rs input (RTI)
- epc  out  DATA_W  saved return address
- flush  out  1  squash instruction in fetch/decode
- imem_req  out  1  fetch request
- halted  out  1  core halted (sticky)
- err  out  1  double fault (sticky)

Behaviour:
- States: RUN, WAIT_MEM, HALTED. Encoding comes from the shared package.
- Reset (rst low, asynchronous):
  - state=RUN, epc=EPC_RST, in_hdl=0, halted=0, err=0.
  - All control outputs are 0 except imem_req=1.
- Control outputs are combinational from state and inputs. Registers update on the rising edge of clk. The PC block samples the controls on the same edge, so a redirect has zero added latency.
- Only one of {pc_sel+reg_jmp combination, siic, halt} is asserted per cycle. The combination itself must match a decode row of the PC block.
- RUN, imem_stall=1:
  - halt=1, imem_req=1, other decisions deferred.
  - Next state WAIT_MEM.
  - Decode inputs are held stable by upstream while the stall persists.
- WAIT_MEM:
  - halt=1 until imem_done=1.
  - In the imem_done cycle, evaluate the RUN priority below and return to RUN.
  - imem_stall and imem_done both high: done wins.
- RUN, not stalled, priority highest first:
  1. halt_instr: halt=1, flush=1, imem_req=0. Next state HALTED.
  2. siic_instr with in_hdl=1: double fault. halt=1, err<=1, halted<=1. Next state HALTED.
  3. siic_instr: siic=1, flush=1, epc<=pc (address after the SIIC), in_hdl<=1.
  4. rti_instr: reg_jmp=1, epc_sel=1, flush=1, in_hdl<=0. rti_instr with in_hdl=0 is still executed.
  5. jr_take: reg_jmp=1, flush=1.
  6. br_take: pc_sel=1, flush=1.
  7. id_stall: halt=1, flush=0.
  8. Otherwise: all controls 0 (PC+2).
- Simultaneous decode strobes resolve purely by this priority; lower strobes are ignored that cycle.
- HALTED: halt=1, imem_req=0, halted=1, all others 0. Only reset exits.
- epc changes only in the SIIC cycle. EPC has no wrap handling: pc=0xFFFE saves 0xFFFE verbatim.
- Reset asserted mid-stall or mid-redirect discards all pending state immediately.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - state typedef/encodings ST_RUN, ST_WAIT_MEM, ST_HALTED;
  - constant EXC_VEC=16'h0002 (must match the PC block);
  - redirect-kind encodings.
- One sub-module is natural: pc_redirect_prio. It is a pure combinational priority encoder that maps the decode strobes and in_hdl to {pc_sel, reg_jmp, halt, siic, epc_sel, flush, kind}.
- pc_seq_ctrl owns the FSM, EPC, in_hdl, halted and err registers.

Test Plan:
- Reset low mid-cycle with br_take=1 -> immediately epc=0, halted=0, err=0, imem_req=1, pc_sel=0; first rising edge after release gives PC+2 (all controls 0).
- pc=0x0040, br_take=1, jr_take=1 same cycle -> reg_jmp=1, pc_sel=0, flush=1 for exactly one cycle.
- imem_stall=1 for 3 cycles with br_take=1 -> halt=1 for 3 cycles, flush=0. Then imem_done=1 -> pc_sel=1, flush=1 that cycle, state RUN.
- pc=0x0124, siic_instr=1 -> siic=1, epc=0x0124 next cycle, in_hdl=1. Later rti_instr=1 -> reg_jmp=1, epc_sel=1, in_hdl=0.
- siic_instr=1 twice without RTI -> second: err=1, halted=1, halt stays 1 for 10+ cycles, imem_req=0.
- halt_instr=1 with id_stall=1 -> HALTED, halted=1, further br_take ignored until rst low.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared state encodings, exception vector and redirect kinds
// for the PC sequencing control path.
package pc_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    // Must match the vector hard-wired in the PC block.
    localparam logic [15:0] EXC_VEC = 16'h0002;

    typedef enum logic [2:0] {
        RK_NONE   = 3'd0,
        RK_BR     = 3'd1,
        RK_JR     = 3'd2,
        RK_RTI    = 3'd3,
        RK_SIIC   = 3'd4,
        RK_HALT   = 3'd5,
        RK_DFAULT = 3'd6,
        RK_STALL  = 3'd7
    } rkind_t;

    function automatic logic rk_stops(input rkind_t k);
        return (k == RK_HALT) || (k == RK_DFAULT);
    endfunction
endpackage

// File: rtl/pc_seq_ctrl_prio.sv
// pc_redirect_prio: combinational priority encoder from decode strobes and
// exception-nesting state to PC block controls and a redirect kind.
module pc_redirect_prio
    import pc_ctrl_pkg::*;
(
    input  logic   i_halt_instr,
    input  logic   i_siic_instr,
    input  logic   i_rti_instr,
    input  logic   i_jr_take,
    input  logic   i_br_take,
    input  logic   i_id_stall,
    input  logic   i_in_hdl,
    output logic   o_pc_sel,
    output logic   o_reg_jmp,
    output logic   o_halt,
    output logic   o_siic,
    output logic   o_epc_sel,
    output logic   o_flush,
    output rkind_t o_kind
);
    always_comb begin
        o_kind = i_halt_instr ? RK_HALT :
                 i_siic_instr ? (i_in_hdl ? RK_DFAULT : RK_SIIC) :
                 i_rti_instr  ? RK_RTI :
                 i_jr_take    ? RK_JR :
                 i_br_take    ? RK_BR :
                 i_id_stall   ? RK_STALL : RK_NONE;
    end

    assign o_pc_sel  = (o_kind == RK_BR);
    assign o_reg_jmp = (o_kind == RK_RTI) || (o_kind == RK_JR);
    assign o_halt    = (o_kind == RK_HALT) || (o_kind == RK_DFAULT) || (o_kind == RK_STALL);
    assign o_siic    = (o_kind == RK_SIIC);
    assign o_epc_sel = (o_kind == RK_RTI);
    // A double fault freezes the core without squashing; the pipeline is dead anyway.
    assign o_flush   = (o_kind == RK_HALT) || (o_kind == RK_SIIC) || (o_kind == RK_RTI) ||
                       (o_kind == RK_JR) || (o_kind == RK_BR);
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC sequencer; arbitrates redirects, stalls, exceptions and halt,
// and owns EPC, exception nesting, halted and double-fault state.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] EPC_RST = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_imem_stall,
    input  logic              i_imem_done,
    input  logic              i_id_stall,
    input  logic              i_br_take,
    input  logic              i_jr_take,
    input  logic              i_halt_instr,
    input  logic              i_siic_instr,
    input  logic              i_rti_instr,
    output logic              o_pc_sel,
    output logic              o_reg_jmp,
    output logic              o_halt,
    output logic              o_siic,
    output logic              o_epc_sel,
    output logic [DATA_W-1:0] o_epc,
    output logic              o_flush,
    output logic              o_imem_req,
    output logic              o_halted,
    output logic              o_err
);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_epc;
    logic              r_in_hdl, r_halted, r_err;
    logic              w_pc_sel, w_reg_jmp, w_halt, w_siic, w_epc_sel, w_flush, w_act;
    rkind_t            w_kind;

    pc_redirect_prio u_prio (
        .i_halt_instr (i_halt_instr),
        .i_siic_instr (i_siic_instr),
        .i_rti_instr  (i_rti_instr),
        .i_jr_take    (i_jr_take),
        .i_br_take    (i_br_take),
        .i_id_stall   (i_id_stall),
        .i_in_hdl     (r_in_hdl),
        .o_pc_sel     (w_pc_sel),
        .o_reg_jmp    (w_reg_jmp),
        .o_halt       (w_halt),
        .o_siic       (w_siic),
        .o_epc_sel    (w_epc_sel),
        .o_flush      (w_flush),
        .o_kind       (w_kind)
    );

    // Decisions are made only when the fetch has completed; done beats a stall.
    assign w_act = ((r_state == ST_RUN) && (!i_imem_stall || i_imem_done)) ||
                   ((r_state == ST_WAIT_MEM) && i_imem_done);

    always_comb begin
        w_next     = r_state;
        o_pc_sel   = 1'b0;
        o_reg_jmp  = 1'b0;
        o_halt     = 1'b0;
        o_siic     = 1'b0;
        o_epc_sel  = 1'b0;
        o_flush    = 1'b0;
        o_imem_req = 1'b1;
        if (i_rst) begin
            if (r_state == ST_HALTED) begin
                o_halt     = 1'b1;
                o_imem_req = 1'b0;
            end else if (w_act) begin
                o_pc_sel   = w_pc_sel;
                o_reg_jmp  = w_reg_jmp;
                o_halt     = w_halt;
                o_siic     = w_siic;
                o_epc_sel  = w_epc_sel;
                o_flush    = w_flush;
                o_imem_req = !rk_stops(w_kind);
                w_next     = rk_stops(w_kind) ? ST_HALTED : ST_RUN;
            end else begin
                o_halt = 1'b1;
                w_next = ST_WAIT_MEM;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= ST_RUN;
            r_epc    <= EPC_RST;
            r_in_hdl <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_act && (w_kind == RK_SIIC)) begin
                r_epc    <= i_pc;
                r_in_hdl <= 1'b1;
            end
            if (w_act && (w_kind == RK_RTI))
                r_in_hdl <= 1'b0;
            if (w_act && rk_stops(w_kind))
                r_halted <= 1'b1;
            if (w_act && (w_kind == RK_DFAULT))
                r_err <= 1'b1;
        end
    end

    assign o_epc    = r_epc;
    assign o_halted = r_halted;
    assign o_err    = r_err;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: vector table, directed corner sequences and randomized
// stimulus against a priority-list reference model.
module tb_pc_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic [15:0] pc = '0;
    logic        imem_stall = 0, imem_done = 0, id_stall = 0, br_take = 0, jr_take = 0;
    logic        halt_instr = 0, siic_instr = 0, rti_instr = 0;
    logic        pc_sel, reg_jmp, halt, siic, epc_sel, flush, imem_req, halted, err;
    logic [15:0] epc;
    logic [6:0]  ctrl;
    int          checks = 0, failures = 0;

    // Control vector bit order: {pc_sel, reg_jmp, halt, siic, epc_sel, flush, imem_req}
    localparam logic [6:0] C_IDLE = 7'b0000001, C_STALL = 7'b0010001, C_HALTED = 7'b0010000;
    localparam logic [6:0] C_BR = 7'b1000011, C_JR = 7'b0100011, C_RTI = 7'b0100111;
    localparam logic [6:0] C_SIIC = 7'b0001011, C_HALTI = 7'b0010010, C_DF = 7'b0010000;

    pc_seq_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_imem_stall(imem_stall), .i_imem_done(imem_done),
        .i_id_stall(id_stall), .i_br_take(br_take), .i_jr_take(jr_take), .i_halt_instr(halt_instr),
        .i_siic_instr(siic_instr), .i_rti_instr(rti_instr), .o_pc_sel(pc_sel), .o_reg_jmp(reg_jmp),
        .o_halt(halt), .o_siic(siic), .o_epc_sel(epc_sel), .o_epc(epc), .o_flush(flush),
        .o_imem_req(imem_req), .o_halted(halted), .o_err(err)
    );

    assign ctrl = {pc_sel, reg_jmp, halt, siic, epc_sel, flush, imem_req};

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    // strobes order: {halt_instr, siic_instr, rti_instr, jr_take, br_take, id_stall}
    task automatic drv(input logic [5:0] s, input logic stl, input logic dn, input logic [15:0] p);
        {halt_instr, siic_instr, rti_instr, jr_take, br_take, id_stall} = s;
        imem_stall = stl;
        imem_done  = dn;
        pc         = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset dropped mid-cycle with current inputs still applied.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
        chk("rst_epc", 32'(epc), 32'h0);
        chk("rst_flags", {30'd0, halted, err}, 32'd0);
        drv(6'b0, 0, 0, 16'h0);
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic       pre_ih;
        logic [5:0] strb;
        logic [6:0] exp;
    } vec_t;

    vec_t vt[10];

    logic [6:0] pat[8] = '{C_HALTI, C_DF, C_SIIC, C_RTI, C_JR, C_BR, C_STALL, C_IDLE};
    logic       m_wait, m_hlt, m_ih, m_err;
    logic [15:0] m_epc;
    logic        pri[7];
    logic [6:0]  m_exp;

    initial begin
        vt[0] = '{0, 6'b000000, C_IDLE};
        vt[1] = '{0, 6'b000010, C_BR};
        vt[2] = '{0, 6'b000110, C_JR};
        vt[3] = '{0, 6'b001100, C_RTI};
        vt[4] = '{0, 6'b011000, C_SIIC};
        vt[5] = '{0, 6'b110000, C_HALTI};
        vt[6] = '{0, 6'b000001, C_STALL};
        vt[7] = '{0, 6'b000011, C_BR};
        vt[8] = '{1, 6'b001000, C_RTI};
        vt[9] = '{0, 6'b001011, C_RTI};

        // Reset mid-cycle with a branch pending, then PC+2 after release.
        drv(6'b000010, 0, 0, 16'h0010);
        #3;
        rst = 1'b1;
        step();
        do_reset();
        #3;
        chk("post_rst_idle", 32'(ctrl), 32'(C_IDLE));

        foreach (vt[i]) begin
            do_reset();
            if (vt[i].pre_ih) begin
                drv(6'b010000, 0, 0, 16'h0200);
                step();
            end
            drv(vt[i].strb, 0, 0, 16'h0300);
            #3;
            chk($sformatf("vec%0d", i), 32'(ctrl), 32'(vt[i].exp));
            step();
        end

        // JR beats BR; flush lasts exactly one cycle.
        do_reset();
        drv(6'b000110, 0, 0, 16'h0040);
        #3;
        chk("jr_over_br", 32'(ctrl), 32'(C_JR));
        step();
        drv(6'b0, 0, 0, 16'h0042);
        #3;
        chk("jr_flush_once", 32'(ctrl), 32'(C_IDLE));

        // Three stalled cycles with a branch held, then done (with stall still high).
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drv(6'b000010, 1, 0, 16'h0050);
            #3;
            chk($sformatf("stall%0d", c), 32'(ctrl), 32'(C_STALL));
            step();
        end
        drv(6'b000010, 1, 1, 16'h0050);
        #3;
        chk("stall_done_br", 32'(ctrl), 32'(C_BR));
        step();
        drv(6'b0, 0, 0, 16'h0052);
        #3;
        chk("stall_back_run", 32'(ctrl), 32'(C_IDLE));

        // SIIC saves EPC, RTI returns and clears nesting, second SIIC is legal.
        do_reset();
        drv(6'b010000, 0, 0, 16'h0124);
        #3;
        chk("siic_ctrl", 32'(ctrl), 32'(C_SIIC));
        step();
        drv(6'b0, 0, 0, 16'h0002);
        #3;
        chk("siic_epc", 32'(epc), 32'h0124);
        step();
        drv(6'b001000, 0, 0, 16'h0004);
        #3;
        chk("rti_ctrl", 32'(ctrl), 32'(C_RTI));
        step();
        drv(6'b010000, 0, 0, 16'hFFFE);
        #3;
        chk("siic_after_rti", 32'(ctrl), 32'(C_SIIC));
        step();
        drv(6'b0, 0, 0, 16'h0002);
        #3;
        chk("epc_nowrap", 32'(epc), 32'hFFFE);

        // Double fault.
        do_reset();
        drv(6'b010000, 0, 0, 16'h0100);
        step();
        drv(6'b0, 0, 0, 16'h0002);
        step();
        drv(6'b010000, 0, 0, 16'h0004);
        #3;
        chk("df_halt", {31'd0, halt}, 32'd1);
        chk("df_req", {31'd0, imem_req}, 32'd0);
        step();
        for (int c = 0; c < 11; c++) begin
            drv(6'(c[0] ? 6'b000010 : 6'b000100), 0, 0, 16'h0010);
            #3;
            chk($sformatf("df_hold%0d", c), {23'd0, ctrl, halted, err}, {23'd0, C_HALTED, 2'b11});
            step();
        end

        // HALT over id_stall; sticky until reset.
        do_reset();
        drv(6'b100001, 0, 0, 16'h0060);
        #3;
        chk("halt_ctrl", 32'(ctrl), 32'(C_HALTI));
        step();
        for (int c = 0; c < 5; c++) begin
            drv(6'b000010, 0, 1, 16'h0062);
            #3;
            chk($sformatf("halted%0d", c), {24'd0, ctrl, halted}, {24'd0, C_HALTED, 1'b1});
            step();
        end
        do_reset();
        #3;
        chk("halt_cleared", {31'd0, halted}, 32'd0);

        // Randomized run against the priority-list model.
        for (int chunk = 0; chunk < 8; chunk++) begin
            do_reset();
            m_wait = 0; m_hlt = 0; m_ih = 0; m_err = 0; m_epc = 16'h0;
            for (int cyc = 0; cyc < 150; cyc++) begin
                drv({$urandom_range(99) < 1, $urandom_range(99) < 8, $urandom_range(99) < 8,
                     $urandom_range(99) < 20, $urandom_range(99) < 30, $urandom_range(99) < 20},
                    $urandom_range(99) < 25, $urandom_range(99) < 30, 16'($urandom_range(32767) * 2));
                #3;
                pri = '{halt_instr, siic_instr && m_ih, siic_instr, rti_instr, jr_take, br_take, id_stall};
                if (m_hlt) m_exp = C_HALTED;
                else if (m_wait ? !imem_done : (imem_stall && !imem_done)) begin
                    m_exp  = C_STALL;
                    m_wait = 1;
                end else begin
                    int k;
                    k = 7;
                    for (int i = 6; i >= 0; i--) if (pri[i]) k = i;
                    m_exp  = pat[k];
                    m_wait = 0;
                    if (k == 0 || k == 1) m_hlt = 1;
                    if (k == 1) m_err = 1;
                    if (k == 2) begin m_epc = pc; m_ih = 1; end
                    if (k == 3) m_ih = 0;
                end
                chk("rnd_ctrl", 32'(ctrl), 32'(m_exp));
                step();
                #3;
                chk("rnd_state", {14'd0, epc, halted, err}, {14'd0, m_epc, m_hlt, m_err});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
